// File: rtl/led_sequencer.sv
// LED pattern engine fed by the WaterLight mode/speed registers.
// Build option LED_SEQ_PWM_EN adds registered brightness gating on led.
module led_sequencer #(
   parameter int             CNT_W      = 32,
   parameter logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(4)
) (
   input  logic             clk,
   input  logic             RSTn,
   input  logic [7:0]       mode,
   input  logic [CNT_W-1:0] speed,
   input  logic [7:0]       bright,
   output logic [7:0]       led,
   output logic             step_pulse,
   output logic             active
);

   localparam logic [7:0] M_ROTL = 8'h01;
   localparam logic [7:0] M_ROTR = 8'h02;
   localparam logic [7:0] M_FLSH = 8'h03;
   localparam logic [7:0] M_PING = 8'h04;

   logic [7:0]       mode_q, mode_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [CNT_W-1:0] per_q, per_d;
   logic [CNT_W-1:0] per_clamp;
   logic             dir_dn, dir_d;
   logic [7:0]       pat, pat_d;
   logic             step_d;
   logic             active_d;

   function automatic logic mode_ok(input logic [7:0] m);
      return (m >= M_ROTL) && (m <= M_PING);
   endfunction

   function automatic logic [7:0] init_pat(input logic [7:0] m);
      logic [7:0] p;
      p = 8'h00;
      unique case (m)
         M_ROTL:  p = 8'h01;
         M_ROTR:  p = 8'h80;
         M_FLSH:  p = 8'hFF;
         M_PING:  p = 8'h01;
         default: p = 8'h00;
      endcase
      return p;
   endfunction

   assign per_clamp = (speed < MIN_PERIOD) ? MIN_PERIOD : speed;

   always_comb begin
      mode_d   = mode_q;
      cnt_d    = cnt;
      per_d    = per_q;
      dir_d    = dir_dn;
      pat_d    = pat;
      step_d   = 1'b0;
      active_d = active;
      // A mode change restarts and takes priority over a terminal count
      if (mode != mode_q) begin
         mode_d   = mode;
         cnt_d    = '0;
         per_d    = per_clamp;
         dir_d    = 1'b0;
         pat_d    = init_pat(mode);
         active_d = mode_ok(mode);
      end else if (!mode_ok(mode_q)) begin
         cnt_d = '0;
         pat_d = 8'h00;
      end else if (cnt == per_q) begin
         cnt_d  = '0;
         per_d  = per_clamp;
         step_d = 1'b1;
         unique case (1'b1)
            (mode_q == M_ROTL): pat_d = {pat[6:0], pat[7]};
            (mode_q == M_ROTR): pat_d = {pat[0], pat[7:1]};
            (mode_q == M_FLSH): pat_d = ~pat;
            (mode_q == M_PING): begin
               if (!dir_dn) begin
                  if (pat == 8'h80) begin
                     dir_d = 1'b1;
                     pat_d = 8'h40;
                  end else begin
                     pat_d = pat << 1;
                  end
               end else begin
                  if (pat == 8'h01) begin
                     dir_d = 1'b0;
                     pat_d = 8'h02;
                  end else begin
                     pat_d = pat >> 1;
                  end
               end
            end
            default: pat_d = pat;
         endcase
      end else begin
         cnt_d = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         mode_q     <= 8'h00;
         cnt        <= '0;
         per_q      <= MIN_PERIOD;
         dir_dn     <= 1'b0;
         pat        <= 8'h00;
         step_pulse <= 1'b0;
         active     <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         cnt        <= cnt_d;
         per_q      <= per_d;
         dir_dn     <= dir_d;
         pat        <= pat_d;
         step_pulse <= step_d;
         active     <= active_d;
      end
   end

`ifdef LED_SEQ_PWM_EN
   logic [7:0] pwm_cnt;
   logic [7:0] led_q;

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         pwm_cnt <= 8'h00;
         led_q   <= 8'h00;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
         led_q   <= pat & {8{pwm_cnt < bright}};
      end
   end

   assign led = led_q;
`else
   logic unused_bright;
   assign unused_bright = ^bright;
   assign led = pat;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: stimulus queues expected strobes,
// a negedge monitor pops and compares them on every step_pulse.
module tb_led_sequencer;

   typedef struct packed {
      logic [31:0] cyc;
      logic [7:0]  led;
   } exp_t;

   logic        clk = 1'b0;
   logic        RSTn;
   logic [7:0]  mode_i;
   logic [31:0] speed_i;
   logic [7:0]  bright_i;
   logic [7:0]  led;
   logic        step_pulse;
   logic        active;

   exp_t        sb[$];
   logic [7:0]  vec[$];
   int          cyc = 0;
   int          checks = 0;
   int          passes = 0;

   led_sequencer dut (
      .clk        (clk),
      .RSTn       (RSTn),
      .mode       (mode_i),
      .speed      (speed_i),
      .bright     (bright_i),
      .led        (led),
      .step_pulse (step_pulse),
      .active     (active)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (step_pulse) begin
         if (sb.size() == 0) begin
            chk("spurious_pulse", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("pulse_cyc", cyc, e.cyc);
            chk("pulse_led", {24'd0, led}, {24'd0, e.led});
         end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         chk("missed_pulse", cyc, 32'hFFFF_FFFF);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick(1);
   endtask

   task automatic push(input int c, input logic [7:0] l);
      exp_t t;
      t.cyc = c;
      t.led = l;
      sb.push_back(t);
   endtask

   task automatic push_vec(input int base, input int per1);
      foreach (vec[i]) push(base + (i + 1) * per1, vec[i]);
   endtask

   task automatic drain(input int last);
      wait_until(last);
      @(negedge clk);
      #1;
      chk("drain", sb.size(), 0);
   endtask

   task automatic start(input logic [7:0] m, input logic [31:0] s,
                        input logic [7:0] init, input logic act,
                        output int base);
      mode_i  = m;
      speed_i = s;
      base    = cyc + 1;
      tick(1);
      chk("init_led", {24'd0, led}, {24'd0, init});
      chk("active", {31'd0, active}, {31'd0, act});
      chk("no_restart_pulse", {31'd0, step_pulse}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int b;
      RSTn     = 1'b0;
      mode_i   = 8'h01;
      speed_i  = 32'd9;
      bright_i = 8'h40;
      tick(3);
      chk("reset_led", {24'd0, led}, 32'd0);
      chk("reset_active", {31'd0, active}, 32'd0);
      chk("reset_pulse", {31'd0, step_pulse}, 32'd0);
      RSTn = 1'b1;
`ifdef LED_SEQ_PWM_EN
      begin
         int ones[8];
         int lit;
         mode_i  = 8'h03;
         speed_i = 32'hFFFF_FFFF;
         tick(6);
         foreach (ones[i]) ones[i] = 0;
         for (int k = 0; k < 256; k++) begin
            for (int i = 0; i < 8; i++) if (led[i]) ones[i]++;
            tick(1);
         end
         for (int i = 0; i < 8; i++) chk("pwm_duty", ones[i], 64);
         bright_i = 8'h00;
         tick(3);
         lit = 0;
         for (int k = 0; k < 256; k++) begin
            if (led != 8'h00) lit++;
            tick(1);
         end
         chk("pwm_off", lit, 0);
      end
`else
      // rotate-left, period 10
      start(8'h01, 32'd9, 8'h01, 1'b1, b);
      vec = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
      push_vec(b, 10);
      drain(b + 90);

      // ping-pong, period 5, no repeats at turnaround
      start(8'h04, 32'd4, 8'h01, 1'b1, b);
      vec = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
              8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
      push_vec(b, 5);
      drain(b + 75);

      // rotate-right, clamped period then a mid-period speed change
      start(8'h02, 32'd1, 8'h80, 1'b1, b);
      wait_until(b + 2);
      speed_i = 32'd20;
      push(b + 5, 8'h40);
      push(b + 26, 8'h20);
      push(b + 47, 8'h10);
      drain(b + 47);

      // flash, then mode change landing on the terminal count
      start(8'h03, 32'd4, 8'hFF, 1'b1, b);
      vec = '{8'h00, 8'hFF};
      push_vec(b, 5);
      drain(b + 10);
      wait_until(b + 14);
      start(8'h01, 32'd4, 8'h01, 1'b1, b);
      push(b + 5, 8'h02);
      drain(b + 5);

      // idle mode
      start(8'h55, 32'd4, 8'h00, 1'b0, b);
      wait_until(b + 20);
      chk("idle_led", {24'd0, led}, 32'd0);
      chk("idle_active", {31'd0, active}, 32'd0);

      // back to a valid mode, then reset mid-period
      start(8'h01, 32'd4, 8'h01, 1'b1, b);
      push(b + 5, 8'h02);
      drain(b + 5);
      wait_until(b + 7);
      RSTn = 1'b0;
      #1;
      chk("async_rst_led", {24'd0, led}, 32'd0);
      chk("async_rst_active", {31'd0, active}, 32'd0);
      tick(2);
      RSTn = 1'b1;
      start(8'h01, 32'd4, 8'h01, 1'b1, b);
      push(b + 5, 8'h02);
      drain(b + 5);

      // maximum speed value: no step within the window
      start(8'h02, 32'hFFFF_FFFF, 8'h80, 1'b1, b);
      tick(40);
      chk("max_speed_hold", {24'd0, led}, 32'h80);
`endif
      tick(2);
      chk("final_drain", sb.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- LED pattern engine directly downstream of the AHB-Lite WaterLight register interface.
- Consumes the mode register (8 bit) and speed register (32 bit), both written by the Cortex-M0. Drives the 8 board LEDs.
- Provides a programmable step prescaler, four pattern modes, restart on mode change, and a step strobe for debug or interrupt use.

Parameters:
- MIN_PERIOD, 32'd4, lower clamp on the effective speed value; smaller speed values use MIN_PERIOD.
- CNT_W, 32, width of the speed input and the prescaler counter.

Ports:
- clk  input  1  system clock (same as HCLK)
- RSTn  input  1  reset, asynchronous, active-low
- mode  input  8  pattern select from the register interface: 01 rotate-left, 02 rotate-right, 03 flash, 04 ping-pong, other values idle
- speed  input  CNT_W  step period minus one, in clk cycles
- bright  input  8  brightness duty; used only with LED_SEQ_PWM_EN
- led  output  8  LED drive, active-high
- step_pulse  output  1  one-cycle strobe on every pattern step
- active  output  1  high when the latched mode is a valid (non-idle) mode

Behaviour:
- Reset: led=8'h00, step_pulse=0, active=0. Internal state: prescaler cnt=0, mode_q=8'h00, dir=up, per_q=MIN_PERIOD.
- Mode latch and change:
  - mode is compared with mode_q on every cycle.
  - On mismatch: at the next edge mode_q<=mode, cnt<=0, per_q<=max(speed,MIN_PERIOD), dir<=up, and the pattern loads the initial value.
  - step_pulse is not asserted on the restart cycle.
- Initial patterns: rotate-left 8'h01; rotate-right 8'h80; flash 8'hFF; ping-pong 8'h01; idle 8'h00.
- Prescaler (valid modes only):
  - cnt increments each cycle.
  - When cnt==per_q: cnt<=0, a step is taken, step_pulse=1 for exactly that following cycle, and per_q<=max(speed,MIN_PERIOD).
  - Step period is per_q+1 cycles.
  - A speed change takes effect only at the next step boundary or mode change; it never truncates the current period.
- Step actions:
  - rotate-left: led<={led[6:0],led[7]}
  - rotate-right: led<={led[0],led[7:1]}
  - flash: led<=~led
  - ping-pong, dir=up: if led==8'h80 then dir<=down, led<=8'h40; else led<=led<<1.
  - ping-pong, dir=down: if led==8'h01 then dir<=up, led<=8'h02; else led<=led>>1.
- Idle mode: cnt held at 0, led=8'h00, step_pulse=0, active=0.
- active is registered: it equals "mode_q is 01..04" and updates in the same cycle mode_q updates.
- Simultaneous mode change and terminal count: the mode change wins. Restart occurs and no step or strobe is issued.
- Speed near limits:
  - speed=32'hFFFF_FFFF is legal; the counter compare is exact and no overflow occurs because cnt resets at per_q.
  - speed<MIN_PERIOD clamps to MIN_PERIOD.
- Asynchronous reset mid-period: all state returns to reset values immediately. After release, the current mode input is treated as a change from 8'h00 and restarts normally one cycle later.
- One pattern state register holds the unmodulated pattern; led is derived from it (see optional feature).

Optional Feature:
- Macro: LED_SEQ_PWM_EN.
- Defined:
  - A free-running 8-bit pwm_cnt is added, reset to 0.
  - led = pattern & {8{pwm_cnt < bright}}, registered, so one cycle of extra output latency applies to both pattern and gating.
  - bright=0 gives LEDs always off; bright=8'hFF gives on 255 of 256 cycles.
- Undefined: led = pattern register directly, the bright port is ignored, and no pwm_cnt exists.

Test Plan:
1. Reset, then mode=01, speed=9: one cycle after release led=8'h01. step_pulse pulses every 10 cycles. led goes 02,04,...,80,01. active=1.
2. mode=04, speed=4: led runs 01,02,...,80,40,...,01,02. The turnaround steps produce no repeated value. Strobe every 5 cycles.
3. mode=02, speed=1 (below MIN_PERIOD=4): step period is 5 cycles. Change speed to 20 mid-period: the current period completes at 5 cycles and the next period is 21.
4. mode=03 running, switch mode to 01 on the same cycle cnt==per_q: no step_pulse. Next cycle led=8'h01, cnt=0. The first step occurs per_q+1 cycles later.
5. mode=8'h55: led=00, active=0, step_pulse never asserts. Back to mode=01: restart with led=8'h01. Also assert RSTn low mid-period: led=00 immediately.
6. LED_SEQ_PWM_EN defined, mode=03, bright=8'h40: over 256 cycles of a steady all-on step, each LED is high for exactly 64 cycles. bright=0 keeps led=00.
